video_timing_meas: RTL and testbench

VIDEO_TIMING_MEAS -- requirements
Module: video_timing_meas

---
 rtl/video_timing_meas.sv | 256 +++++++++++++++++++++++++
 tb/tb_video_timing_meas.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/video_timing_meas.sv
// Measures horizontal/vertical timing of a sync+DE video stream and publishes
// the mode once STABLE_FRAMES identical complete frames have been observed.
module video_timing_meas #(
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned H_TIMEOUT     = 4095,
  parameter int unsigned V_TIMEOUT     = 2047
) (
  input  logic        clk27,
  input  logic        reset_n,
  input  logic        HSYNC_in,
  input  logic        VSYNC_in,
  input  logic        DE_in,
  output logic [11:0] h_total,
  output logic [11:0] h_synclen,
  output logic [11:0] h_start,
  output logic [11:0] h_active,
  output logic [10:0] v_total,
  output logic [10:0] v_synclen,
  output logic [10:0] v_start,
  output logic [10:0] v_active,
  output logic        mode_valid,
  output logic        mode_changed
);

  localparam int unsigned HW = 12;
  localparam int unsigned VW = 11;
  localparam int unsigned SW = 3;
  localparam logic [HW-1:0] H_TO = HW'(H_TIMEOUT);
  localparam logic [VW-1:0] V_TO = VW'(V_TIMEOUT);
  localparam logic [SW-1:0] ST_N = SW'(STABLE_FRAMES);

  typedef enum logic [1:0] {NOSIG = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] stable_cnt_q, stable_cnt_d;

  logic          hs_q, hs_p_q, vs_q, vs_ls_q, de_q, de_p_q;
  logic [HW-1:0] h_cnt_q, de_cnt_q, ln_sync_q, ln_start_q, ln_act_q;
  logic          line_de_q;
  logic          f_first_q, f_incons_q, f_hcap_q, f_vcap_q;
  logic [HW-1:0] f_htot_q, f_hsync_q, f_hstart_q, f_hact_q;
  logic [VW-1:0] v_cnt_q, f_vsync_q, f_vstart_q, f_vact_q;
  logic [HW-1:0] p_htot_q, p_hsync_q, p_hstart_q, p_hact_q;
  logic [VW-1:0] p_vtot_q, p_vsync_q, p_vstart_q, p_vact_q;

  logic          hs_lead, hs_trail, de_rise, de_fall, frame_start, timeout;
  logic          take_h, take_v, cl_incons, same_prev, publish;
  logic [HW-1:0] line_len, cl_htot, cl_hsync, cl_hstart, cl_hact;
  logic [VW-1:0] cl_vtot, cl_vsync, cl_vstart, cl_vact;

  assign hs_lead     = hs_p_q & ~hs_q;
  assign hs_trail    = ~hs_p_q & hs_q;
  assign de_rise     = ~de_p_q & de_q;
  assign de_fall     = de_p_q & ~de_q;
  assign frame_start = hs_lead & ~vs_q & vs_ls_q;
  assign timeout     = (h_cnt_q == H_TO) | (v_cnt_q == V_TO);
  assign line_len    = h_cnt_q + 12'd1;

  // Frame totals including the line that ends at this HSYNC leading edge
  assign take_h    = line_de_q & ~f_hcap_q;
  assign take_v    = line_de_q & ~f_vcap_q;
  assign cl_htot   = f_first_q ? f_htot_q : line_len;
  assign cl_incons = f_incons_q | (f_first_q & (line_len != f_htot_q));
  assign cl_hsync  = take_h ? ln_sync_q  : f_hsync_q;
  assign cl_hstart = take_h ? ln_start_q : f_hstart_q;
  assign cl_hact   = take_h ? ln_act_q   : f_hact_q;
  assign cl_vtot   = v_cnt_q + 11'd1;
  assign cl_vsync  = f_vsync_q;
  assign cl_vstart = take_v ? v_cnt_q : f_vstart_q;
  assign cl_vact   = f_vact_q + (line_de_q ? 11'd1 : 11'd0);
  assign same_prev = (cl_htot == p_htot_q) && (cl_hsync == p_hsync_q) &&
                     (cl_hstart == p_hstart_q) && (cl_hact == p_hact_q) &&
                     (cl_vtot == p_vtot_q) && (cl_vsync == p_vsync_q) &&
                     (cl_vstart == p_vstart_q) && (cl_vact == p_vact_q);

  // Input sampling; syncs idle high so reset them inactive to avoid a false edge
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      hs_q   <= 1'b1;
      hs_p_q <= 1'b1;
      vs_q   <= 1'b1;
      de_q   <= 1'b0;
      de_p_q <= 1'b0;
    end else begin
      hs_q   <= HSYNC_in;
      hs_p_q <= hs_q;
      vs_q   <= VSYNC_in;
      de_q   <= DE_in;
      de_p_q <= de_q;
    end
  end

  // Per-line horizontal measurement
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q    <= '0;
      de_cnt_q   <= '0;
      line_de_q  <= 1'b0;
      ln_sync_q  <= '0;
      ln_start_q <= '0;
      ln_act_q   <= '0;
    end else begin
      if (hs_lead) begin
        h_cnt_q   <= '0;
        de_cnt_q  <= de_q ? 12'd1 : 12'd0;
        line_de_q <= de_q;
      end else begin
        if (h_cnt_q != H_TO) h_cnt_q <= h_cnt_q + 12'd1;
        if (de_q) de_cnt_q <= de_cnt_q + 12'd1;
        line_de_q <= line_de_q | de_q;
      end
      if (hs_trail) ln_sync_q  <= line_len;
      if (de_rise)  ln_start_q <= line_len;
      if (de_fall)  ln_act_q   <= de_cnt_q;
    end
  end

  // Per-frame accumulation and snapshot of the previous complete frame
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      vs_ls_q    <= 1'b0;
      v_cnt_q    <= '0;
      f_first_q  <= 1'b0;
      f_incons_q <= 1'b0;
      f_hcap_q   <= 1'b0;
      f_vcap_q   <= 1'b0;
      f_htot_q   <= '0;
      f_hsync_q  <= '0;
      f_hstart_q <= '0;
      f_hact_q   <= '0;
      f_vsync_q  <= '0;
      f_vstart_q <= '0;
      f_vact_q   <= '0;
      p_htot_q   <= '0;
      p_hsync_q  <= '0;
      p_hstart_q <= '0;
      p_hact_q   <= '0;
      p_vtot_q   <= '0;
      p_vsync_q  <= '0;
      p_vstart_q <= '0;
      p_vact_q   <= '0;
    end else if (hs_lead) begin
      vs_ls_q <= vs_q;
      if (frame_start) begin
        v_cnt_q    <= '0;
        f_first_q  <= 1'b0;
        f_incons_q <= 1'b0;
        f_hcap_q   <= 1'b0;
        f_vcap_q   <= 1'b0;
        f_htot_q   <= '0;
        f_hsync_q  <= '0;
        f_hstart_q <= '0;
        f_hact_q   <= '0;
        f_vsync_q  <= 11'd1;
        f_vstart_q <= '0;
        f_vact_q   <= '0;
        p_htot_q   <= cl_htot;
        p_hsync_q  <= cl_hsync;
        p_hstart_q <= cl_hstart;
        p_hact_q   <= cl_hact;
        p_vtot_q   <= cl_vtot;
        p_vsync_q  <= cl_vsync;
        p_vstart_q <= cl_vstart;
        p_vact_q   <= cl_vact;
      end else begin
        if (v_cnt_q != V_TO) v_cnt_q <= v_cnt_q + 11'd1;
        f_first_q  <= 1'b1;
        f_incons_q <= cl_incons;
        f_hcap_q   <= f_hcap_q | line_de_q;
        f_vcap_q   <= f_vcap_q | line_de_q;
        f_htot_q   <= cl_htot;
        f_hsync_q  <= cl_hsync;
        f_hstart_q <= cl_hstart;
        f_hact_q   <= cl_hact;
        f_vsync_q  <= f_vsync_q + (vs_q ? 11'd0 : 11'd1);
        f_vstart_q <= cl_vstart;
        f_vact_q   <= cl_vact;
      end
    end
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= NOSIG;
      stable_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
    end
  end

  // Lock qualification; timeout wins over a coincident frame start
  always_comb begin
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    if (timeout) begin
      state_d      = NOSIG;
      stable_cnt_d = '0;
    end else if (frame_start) begin
      case (state_q)
        NOSIG: begin
          state_d      = ACQUIRE;
          stable_cnt_d = '0;
        end
        ACQUIRE: begin
          if (!cl_incons && (stable_cnt_q != '0) && same_prev)
            stable_cnt_d = stable_cnt_q + 3'd1;
          else
            stable_cnt_d = cl_incons ? 3'd0 : 3'd1;
          if (stable_cnt_d >= ST_N) state_d = LOCKED;
        end
        LOCKED: begin
          if (cl_incons || !same_prev) begin
            state_d      = ACQUIRE;
            stable_cnt_d = cl_incons ? 3'd0 : 3'd1;
          end
        end
        default: begin
          state_d      = NOSIG;
          stable_cnt_d = '0;
        end
      endcase
    end
  end

  assign publish = (state_q != LOCKED) && (state_d == LOCKED);

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      mode_valid   <= 1'b0;
      mode_changed <= 1'b0;
      h_total      <= '0;
      h_synclen    <= '0;
      h_start      <= '0;
      h_active     <= '0;
      v_total      <= '0;
      v_synclen    <= '0;
      v_start      <= '0;
      v_active     <= '0;
    end else begin
      mode_valid   <= (state_d == LOCKED);
      mode_changed <= (state_d == LOCKED) != (state_q == LOCKED);
      if (publish) begin
        h_total   <= cl_htot;
        h_synclen <= cl_hsync;
        h_start   <= cl_hstart;
        h_active  <= cl_hact;
        v_total   <= cl_vtot;
        v_synclen <= cl_vsync;
        v_start   <= cl_vstart;
        v_active  <= cl_vact;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_meas.sv
// Directed bench for video_timing_meas using a scaled-down raster
// (40 px lines, 20-line frames) so every scenario fits a short run.
module tb_video_timing_meas;

  localparam int HT  = 40;
  localparam int HS  = 6;
  localparam int HST = 10;
  localparam int HA  = 24;
  localparam int VT  = 20;
  localparam int VS  = 3;
  localparam int VST = 5;
  localparam int VA  = 12;
  localparam int HTO = 200;

  logic        clk27 = 1'b0;
  logic        reset_n = 1'b0;
  logic        hs = 1'b1;
  logic        vs = 1'b1;
  logic        de = 1'b0;
  logic [11:0] h_total, h_synclen, h_start, h_active;
  logic [10:0] v_total, v_synclen, v_start, v_active;
  logic        mode_valid, mode_changed;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk27 = ~clk27;

  video_timing_meas #(.STABLE_FRAMES(2), .H_TIMEOUT(HTO), .V_TIMEOUT(2047)) dut (
    .clk27(clk27), .reset_n(reset_n),
    .HSYNC_in(hs), .VSYNC_in(vs), .DE_in(de),
    .h_total(h_total), .h_synclen(h_synclen), .h_start(h_start), .h_active(h_active),
    .v_total(v_total), .v_synclen(v_synclen), .v_start(v_start), .v_active(v_active),
    .mode_valid(mode_valid), .mode_changed(mode_changed)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic px(input logic h, input logic v, input logic d);
    @(negedge clk27);
    hs = h;
    vs = v;
    de = d;
  endtask

  task automatic line(input int len, input logic v, input logic den, input int p0);
    for (int p = p0; p < len; p++)
      px((p < HS) ? 1'b0 : 1'b1, v, den && (p >= HST) && (p < HST + HA));
  endtask

  // Lines l0..l1-1; lines below split use length la, the rest lb
  task automatic frame(input int la, input int lb, input int split,
                       input int l0, input int p0, input int l1);
    for (int l = l0; l < l1; l++)
      line((l < split) ? la : lb, (l < VS) ? 1'b0 : 1'b1,
           (l >= VST) && (l < VST + VA), (l == l0) ? p0 : 0);
  endtask

  // First four pixels of a frame, checking mode_valid around the VSYNC edge
  task automatic fs(input logic pre, input logic post);
    px(1'b0, 1'b0, 1'b0);
    px(1'b0, 1'b0, 1'b0);
    chk("mv_before_edge", mode_valid, pre);
    chk("mc_before_edge", mode_changed, 1'b0);
    px(1'b0, 1'b0, 1'b0);
    chk("mv_after_edge", mode_valid, post);
    chk("mc_pulse", mode_changed, pre != post);
    px(1'b0, 1'b0, 1'b0);
    chk("mc_single", mode_changed, 1'b0);
  endtask

  task automatic check_values(input int htot);
    chk("h_total", h_total, htot);
    chk("h_synclen", h_synclen, HS);
    chk("h_start", h_start, HST);
    chk("h_active", h_active, HA);
    chk("v_total", v_total, VT);
    chk("v_synclen", v_synclen, VS);
    chk("v_start", v_start, VST);
    chk("v_active", v_active, VA);
  endtask

  task automatic check_zero();
    chk("zero_mv", mode_valid, 0);
    chk("zero_mc", mode_changed, 0);
    chk("zero_h_total", h_total, 0);
    chk("zero_h_synclen", h_synclen, 0);
    chk("zero_h_start", h_start, 0);
    chk("zero_h_active", h_active, 0);
    chk("zero_v_total", v_total, 0);
    chk("zero_v_synclen", v_synclen, 0);
    chk("zero_v_start", v_start, 0);
    chk("zero_v_active", v_active, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk27);
    check_zero();
    reset_n = 1'b1;
    repeat (4) px(1'b1, 1'b1, 1'b0);
    frame(HT, HT, 0, VT - 3, 0, VT);

    // Acquisition: lock at the third frame start
    frame(HT, HT, 0, 0, 0, VT);
    chk("mv_f1", mode_valid, 0);
    frame(HT, HT, 0, 0, 0, VT);
    chk("mv_f2", mode_valid, 0);
    fs(1'b0, 1'b1);
    check_values(HT);
    frame(HT, HT, 0, 0, 4, VT);
    fs(1'b1, 1'b1);
    frame(HT, HT, 0, 0, 4, VT);

    // Line length changes mid-frame: drop, then relock two frames later
    fs(1'b1, 1'b1);
    frame(HT, HT + 4, 10, 0, 4, VT);
    fs(1'b1, 1'b0);
    chk("retained_h_total", h_total, HT);
    frame(HT + 4, HT + 4, 0, 0, 4, VT);
    fs(1'b0, 1'b0);
    chk("stable_cnt_after_first", dut.stable_cnt_q, 1);
    frame(HT + 4, HT + 4, 0, 0, 4, VT);
    fs(1'b0, 1'b1);
    check_values(HT + 4);
    frame(HT + 4, HT + 4, 0, 0, 4, VT);

    // HSYNC stops: loss exactly HTO+2 cycles after the last leading edge
    fs(1'b1, 1'b1);
    frame(HT + 4, HT + 4, 0, 0, 4, 5);
    px(1'b0, 1'b1, 1'b0);
    for (int j = 1; j <= HTO + 1; j++) px((j < HS) ? 1'b0 : 1'b1, 1'b1, 1'b0);
    px(1'b1, 1'b1, 1'b0);
    chk("mv_before_timeout", mode_valid, 1);
    px(1'b1, 1'b1, 1'b0);
    chk("mv_at_timeout", mode_valid, 0);
    chk("mc_at_timeout", mode_changed, 1);
    px(1'b1, 1'b1, 1'b0);
    chk("mc_after_timeout", mode_changed, 0);
    check_values(HT + 4);

    // One short line per frame keeps every frame inconsistent
    for (int f = 0; f < 4; f++) begin
      frame(HT - 1, HT, 1, 0, 0, VT);
      chk("mv_glitch", mode_valid, 0);
      chk("stable_cnt_glitch", dut.stable_cnt_q, 0);
    end

    // Relock, then reset mid-frame and relock with identical values
    frame(HT, HT, 0, 0, 0, VT);
    frame(HT, HT, 0, 0, 0, VT);
    fs(1'b0, 1'b1);
    check_values(HT);
    frame(HT, HT, 0, 0, 4, 10);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero();
    frame(HT, HT, 0, 10, 0, 11);
    reset_n = 1'b1;
    frame(HT, HT, 0, 11, 0, VT);
    frame(HT, HT, 0, 0, 0, VT);
    chk("mv_after_reset_f1", mode_valid, 0);
    frame(HT, HT, 0, 0, 0, VT);
    chk("mv_after_reset_f2", mode_valid, 0);
    fs(1'b0, 1'b1);
    check_values(HT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
